// File: rtl/conv_pkg.sv
// Shared constants and state encoding for the 2D convolution processor.
// The MAC and output-streaming blocks import the same definitions.
package conv_pkg;

  localparam int IMG_W = 8;
  localparam int IMG_H = 8;
  localparam int K     = 3;
  localparam int DW    = 8;
  localparam int AW    = 6;

  localparam int OUT_W = IMG_W - K + 1;
  localparam int OUT_H = IMG_H - K + 1;

  // Width of the output-grid row/column coordinates.
  localparam int RC_W  = 3;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DRAIN,
    ISSUE,
    DONE
  } state_t;

endpackage

// File: rtl/conv_win_gather.sv
// Combinational K x K window selection out of the frame buffer.
// The result is packed row-major with the top-left pixel in the LSBs.
module conv_win_gather #(
  parameter int IMG_W = conv_pkg::IMG_W,
  parameter int NPIX  = conv_pkg::IMG_W * conv_pkg::IMG_H,
  parameter int K     = conv_pkg::K,
  parameter int DW    = conv_pkg::DW,
  parameter int AW    = conv_pkg::AW,
  parameter int RC_W  = conv_pkg::RC_W
) (
  input  logic [DW-1:0]     pix [NPIX],
  input  logic [RC_W-1:0]   row,
  input  logic [RC_W-1:0]   col,
  output logic [K*K*DW-1:0] win
);

  import conv_pkg::*;

  // Pick pixel (row+i, col+j) for every kernel tap.
  always_comb begin
    win = '0;
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K; j++) begin
        win[(i*K + j)*DW +: DW] = pix[AW'((int'(row) + i) * IMG_W + int'(col) + j)];
      end
    end
  end

endmodule

// File: rtl/conv_frame_ctrl.sv
// Frame sequencer: loads one image from the pixel RAM into a local buffer,
// then hands every valid K x K window to the MAC datapath in raster order
// over a valid/ready handshake and pulses done when the frame is finished.
module conv_frame_ctrl #(
  parameter int IMG_W = conv_pkg::IMG_W,
  parameter int IMG_H = conv_pkg::IMG_H,
  parameter int K     = conv_pkg::K,
  parameter int AW    = conv_pkg::AW,
  parameter int DW    = conv_pkg::DW
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic                      ram_rd,
  output logic [AW-1:0]             ram_addr,
  input  logic [DW-1:0]             ram_dout,
  output logic                      win_valid,
  input  logic                      win_ready,
  output logic [K*K*DW-1:0]         win_data,
  output logic [conv_pkg::RC_W-1:0] win_row,
  output logic [conv_pkg::RC_W-1:0] win_col,
  output logic                      win_last,
  output logic                      busy,
  output logic                      done
);

  import conv_pkg::*;

  localparam int NPIX     = IMG_W * IMG_H;
  localparam int OUT_COLS = IMG_W - K + 1;
  localparam int OUT_ROWS = IMG_H - K + 1;

  localparam logic [AW-1:0]   LAST_ADDR = AW'(NPIX - 1);
  localparam logic [RC_W-1:0] LAST_COL  = RC_W'(OUT_COLS - 1);
  localparam logic [RC_W-1:0] LAST_ROW  = RC_W'(OUT_ROWS - 1);

  state_t state;
  state_t next_state;

  logic              cap_valid;
  logic [AW-1:0]     cap_addr;
  logic [DW-1:0]     frame_buf [NPIX];

  logic [RC_W-1:0]   req_row;
  logic [RC_W-1:0]   req_col;
  logic [K*K*DW-1:0] gathered;

  logic              handshake;
  logic              at_last;

  logic              ram_rd_n;
  logic              win_valid_n;
  logic              busy_n;
  logic              done_n;

  assign handshake = win_valid & win_ready;
  assign at_last   = (win_row == LAST_ROW) && (win_col == LAST_COL);

  // State register; reset always returns to IDLE.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic; start is only honoured while IDLE.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = LOAD;
      LOAD:    if (ram_addr == LAST_ADDR) next_state = DRAIN;
      DRAIN:   next_state = ISSUE;
      ISSUE:   if (handshake && at_last) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Window coordinate to present next cycle: (0,0) leaving DRAIN, else advance on handshake.
  always_comb begin
    req_row = '0;
    req_col = '0;
    if (state == ISSUE) begin
      req_row = win_row;
      req_col = win_col;
      if (handshake) begin
        if (win_col == LAST_COL) begin
          req_col = '0;
          req_row = win_row + 1'b1;
        end else begin
          req_col = win_col + 1'b1;
        end
      end
    end
  end

  // Next-cycle values of the status outputs, decoded from the upcoming state.
  always_comb begin
    ram_rd_n    = (next_state == LOAD);
    win_valid_n = (next_state == ISSUE);
    busy_n      = (next_state == LOAD) || (next_state == DRAIN) || (next_state == ISSUE);
    done_n      = (next_state == DONE);
  end

  // Registered outputs; the read address doubles as the load counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      ram_rd    <= 1'b0;
      ram_addr  <= '0;
      win_valid <= 1'b0;
      win_data  <= '0;
      win_row   <= '0;
      win_col   <= '0;
      win_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      ram_rd    <= ram_rd_n;
      win_valid <= win_valid_n;
      busy      <= busy_n;
      done      <= done_n;
      if (next_state == LOAD) ram_addr <= (state == LOAD) ? ram_addr + 1'b1 : '0;
      else                    ram_addr <= '0;
      win_row   <= win_valid_n ? req_row  : '0;
      win_col   <= win_valid_n ? req_col  : '0;
      win_data  <= win_valid_n ? gathered : '0;
      win_last  <= win_valid_n && (req_row == LAST_ROW) && (req_col == LAST_COL);
    end
  end

  // Remember which address was read so its data can be stored one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_valid <= 1'b0;
      cap_addr  <= '0;
    end else begin
      cap_valid <= ram_rd;
      cap_addr  <= ram_addr;
    end
  end

  // Frame buffer write; the last pixel lands at the end of DRAIN, which is
  // safe because the first window never covers the final pixel.
  always_ff @(posedge clk) begin
    if (cap_valid) frame_buf[cap_addr] <= ram_dout;
  end

  conv_win_gather #(
    .IMG_W (IMG_W),
    .NPIX  (NPIX),
    .K     (K),
    .DW    (DW),
    .AW    (AW),
    .RC_W  (RC_W)
  ) u_gather (
    .pix (frame_buf),
    .row (req_row),
    .col (req_col),
    .win (gathered)
  );

endmodule

// File: tb/tb_conv_frame_ctrl.sv
// Self-checking bench for conv_frame_ctrl: a registered RAM model, an
// arithmetic window reference and directed plus randomised frames.
module tb_conv_frame_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        ram_rd;
  logic [5:0]  ram_addr;
  logic [7:0]  ram_dout = '0;
  logic        win_valid;
  logic        win_ready;
  logic [71:0] win_data;
  logic [2:0]  win_row;
  logic [2:0]  win_col;
  logic        win_last;
  logic        busy;
  logic        done;

  int checks   = 0;
  int failures = 0;

  logic [7:0] mem [64];

  conv_frame_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .ram_rd    (ram_rd),
    .ram_addr  (ram_addr),
    .ram_dout  (ram_dout),
    .win_valid (win_valid),
    .win_ready (win_ready),
    .win_data  (win_data),
    .win_row   (win_row),
    .win_col   (win_col),
    .win_last  (win_last),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Single-port RAM: data appears one cycle after the address.
  always @(posedge clk) begin
    if (ram_rd) ram_dout <= mem[ram_addr];
  end

  // Hard stop in case something hangs outside the bounded loops.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic s, input logic r);
    start     = s;
    win_ready = r;
  endtask

  task automatic checkOutput(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Window k of the 6x6 grid in raster order, taken straight from the image.
  function automatic logic [71:0] expWin(input int k);
    logic [71:0] w;
    int r;
    int c;
    r = k / 6;
    c = k % 6;
    w = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w[(i*3 + j)*8 +: 8] = mem[6'((r + i) * 8 + c + j)];
    return w;
  endfunction

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_ram_rd"},    72'(ram_rd),    72'(0));
    checkOutput({tag, "_ram_addr"},  72'(ram_addr),  72'(0));
    checkOutput({tag, "_win_valid"}, 72'(win_valid), 72'(0));
    checkOutput({tag, "_win_data"},  win_data,       72'(0));
    checkOutput({tag, "_win_row"},   72'(win_row),   72'(0));
    checkOutput({tag, "_win_col"},   72'(win_col),   72'(0));
    checkOutput({tag, "_win_last"},  72'(win_last),  72'(0));
    checkOutput({tag, "_busy"},      72'(busy),      72'(0));
    checkOutput({tag, "_done"},      72'(done),      72'(0));
  endtask

  // Runs one whole frame from an IDLE negedge; mode 0 ready=1, 1 toggling
  // (stall phase first), 2 random. Ends on the IDLE cycle after done.
  task automatic runFrame(input int mode, input int ignStartCyc, input int doneCyc);
    int   cyc;
    int   k;
    int   stalls;
    logic rdy;
    applyStimulus(1'b1, 1'b0);
    @(negedge clk);
    cyc = 1;
    applyStimulus(1'b0, 1'b0);
    for (int a = 0; a < 64; a++) begin
      checkOutput("load_ram_rd",   72'(ram_rd),    72'(1));
      checkOutput("load_ram_addr", 72'(ram_addr),  72'(a));
      checkOutput("load_busy",     72'(busy),      72'(1));
      checkOutput("load_valid",    72'(win_valid), 72'(0));
      @(negedge clk);
      cyc++;
    end
    checkOutput("drain_ram_rd", 72'(ram_rd),    72'(0));
    checkOutput("drain_busy",   72'(busy),      72'(1));
    checkOutput("drain_valid",  72'(win_valid), 72'(0));
    checkOutput("drain_cycle",  72'(cyc),       72'(65));
    @(negedge clk);
    cyc++;
    k      = 0;
    stalls = 0;
    while (k < 36 && cyc < 600) begin
      checkOutput("issue_valid",  72'(win_valid), 72'(1));
      checkOutput("issue_busy",   72'(busy),      72'(1));
      checkOutput("issue_ram_rd", 72'(ram_rd),    72'(0));
      checkOutput("issue_done",   72'(done),      72'(0));
      checkOutput("win_row",      72'(win_row),   72'(k / 6));
      checkOutput("win_col",      72'(win_col),   72'(k % 6));
      checkOutput("win_last",     72'(win_last),  72'(k == 35));
      checkOutput("win_data",     win_data,       expWin(k));
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = ((cyc - 66) % 2) == 1;
        default: rdy = ($urandom_range(0, 3) != 0);
      endcase
      applyStimulus(cyc == ignStartCyc, rdy);
      if (rdy) k++;
      else     stalls++;
      @(negedge clk);
      cyc++;
    end
    applyStimulus(1'b0, 1'b0);
    checkOutput("handshakes", 72'(k),         72'(36));
    checkOutput("done_pulse", 72'(done),      72'(1));
    checkOutput("done_valid", 72'(win_valid), 72'(0));
    checkOutput("done_busy",  72'(busy),      72'(0));
    checkOutput("done_cycle", 72'(cyc),       72'(102 + stalls));
    if (doneCyc > 0) checkOutput("done_cycle_abs", 72'(cyc), 72'(doneCyc));
    @(negedge clk);
    checkIdle("after_done");
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0);
    for (int a = 0; a < 64; a++) mem[a] = 8'(a);
    repeat (3) @(negedge clk);
    checkIdle("reset");
    rst = 1'b0;
    @(negedge clk);
    checkIdle("post_reset");

    $display("[TB] frame with ready held high");
    runFrame(0, -1, 102);

    $display("[TB] frame with ready toggling");
    runFrame(1, -1, 138);

    $display("[TB] start pulse during ISSUE is ignored");
    runFrame(0, 80, 102);

    $display("[TB] reset in the middle of LOAD");
    applyStimulus(1'b1, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0);
    repeat (29) @(negedge clk);
    checkOutput("midload_addr", 72'(ram_addr), 72'(29));
    rst = 1'b1;
    @(negedge clk);
    checkIdle("rst_midload");
    rst = 1'b0;
    @(negedge clk);
    runFrame(0, -1, 102);

    $display("[TB] back-to-back frame with inverted image");
    for (int a = 0; a < 64; a++) mem[a] = 8'(255 - a);
    runFrame(0, -1, 102);

    $display("[TB] reset in the middle of ISSUE");
    applyStimulus(1'b1, 1'b1);
    @(negedge clk);
    applyStimulus(1'b0, 1'b1);
    repeat (75) @(negedge clk);
    checkOutput("midissue_valid", 72'(win_valid), 72'(1));
    rst = 1'b1;
    @(negedge clk);
    checkIdle("rst_midissue");
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0);
    @(negedge clk);

    $display("[TB] random images with random ready");
    for (int f = 0; f < 3; f++) begin
      for (int a = 0; a < 64; a++) mem[a] = 8'($urandom_range(0, 255));
      runFrame(2, -1, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
